// File: rtl/givens_pkg.sv
// givens_pkg: shared types and constants for the Givens rotation datapath and its request arbiter.
package givens_pkg;

  typedef logic [31:0] fp32_t;

  localparam int GIVENS_LAT    = 34;
  localparam int GIVENS_NREQ   = 4;
  localparam int GIVENS_TAG_W  = 4;
  localparam int GIVENS_ID_W   = $clog2(GIVENS_NREQ);
  localparam int GIVENS_CNT_W  = 16;

  // One slot of the in-flight tracker for the default configuration.
  typedef struct packed {
    logic                    vld;
    logic [GIVENS_ID_W-1:0]  id;
    logic [GIVENS_TAG_W-1:0] tag;
  } inflight_t;

  typedef logic [GIVENS_CNT_W-1:0] cnt_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant over a request vector.
// The last-grant pointer moves only when the caller signals that the grant was taken.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    // NOTE: every output is given a default before the search, so no path holds a stale value (no latch).
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    found     = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = IDX_W'((int'(last_grant) + k) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= IDX_W'(N - 1);
    end else if (advance) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/givens_arbiter.sv
// givens_arbiter: shares one fully pipelined Givens rotation unit among NREQ requesters and routes results back.
// Build macro GIVENS_ARB_STATS_EN adds per-requester issue counters and a conflict counter.
module givens_arbiter
  import givens_pkg::*;
#(
  parameter int NREQ    = GIVENS_NREQ,
  parameter int ROT_LAT = GIVENS_LAT,
  parameter int TAG_W   = GIVENS_TAG_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*32-1:0]    req_a,
  input  logic [NREQ*32-1:0]    req_b,
  input  logic [NREQ*TAG_W-1:0] req_tag,
  output fp32_t                 rot_a,
  output fp32_t                 rot_b,
  input  fp32_t                 rot_cos,
  input  fp32_t                 rot_sin,
  output logic [NREQ-1:0]       resp_valid,
  output fp32_t                 resp_cos,
  output fp32_t                 resp_sin,
  output logic [TAG_W-1:0]      resp_tag,
  output logic                  busy
`ifdef GIVENS_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]    issue_cnt,
  output logic [15:0]           conflict_cnt
`endif
);

  localparam int ID_W = $clog2(NREQ);

  typedef struct packed {
    logic             vld;
    logic [ID_W-1:0]  id;
    logic [TAG_W-1:0] tag;
  } slot_t;

  logic [NREQ-1:0]  grant;
  logic [ID_W-1:0]  grant_idx;
  logic             handshake;
  fp32_t            sel_a;
  fp32_t            sel_b;
  logic [TAG_W-1:0] sel_tag;
  slot_t            push_slot;
  slot_t            head;
  slot_t            pipe [ROT_LAT+1];

  rr_arbiter #(.N(NREQ)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .advance   (handshake),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // The arbiter only grants valid requesters, so ready is a strict subset of valid.
  assign req_ready = reset ? '0 : grant;
  assign handshake = |req_ready;

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_tag = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a   = req_a[32*i +: 32];
        sel_b   = req_b[32*i +: 32];
        sel_tag = req_tag[TAG_W*i +: TAG_W];
      end
    end
  end

  // Idle cycles feed zeros so the rotation unit never sees a stale pair.
  always_ff @(posedge clk) begin
    if (reset || !handshake) begin
      rot_a <= '0;
      rot_b <= '0;
    end else begin
      rot_a <= sel_a;
      rot_b <= sel_b;
    end
  end

  always_comb begin
    push_slot = '0;
    if (handshake) begin
      push_slot.vld = 1'b1;
      push_slot.id  = grant_idx;
      push_slot.tag = sel_tag;
    end
  end

  // NOTE: the whole tracker is reset, not just vld, so the don't-care response payload is never X after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= ROT_LAT; k++) begin
        pipe[k] <= '0;
      end
    end else begin
      pipe[0] <= push_slot;
      for (int k = 1; k <= ROT_LAT; k++) begin
        pipe[k] <= pipe[k-1];
      end
    end
  end

  // Head lines up with the rotation unit output one issue-register stage plus ROT_LAT later.
  assign head     = pipe[ROT_LAT];
  assign resp_cos = rot_cos;
  assign resp_sin = rot_sin;
  assign resp_tag = head.tag;

  always_comb begin
    resp_valid = '0;
    if (head.vld && !reset) begin
      resp_valid[head.id] = 1'b1;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k <= ROT_LAT; k++) begin
      busy = busy | pipe[k].vld;
    end
  end

`ifdef GIVENS_ARB_STATS_EN
  cnt_t issue_q [NREQ];
  cnt_t conflict_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) begin
        issue_q[i] <= '0;
      end
      conflict_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          issue_q[i] <= sat_inc(issue_q[i]);
        end
      end
      if ($countones(req_valid) >= 2) begin
        conflict_q <= sat_inc(conflict_q);
      end
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_issue
    assign issue_cnt[16*i +: 16] = issue_q[i];
  end

  assign conflict_cnt = conflict_q;
`endif

endmodule
